// File: rtl/tetris_input_pkg.sv
// tetris_input_pkg: shared definitions for the tetris push-button front end.
`default_nettype none

package tetris_input_pkg;

  localparam int BTN_DOWN  = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 2;
  localparam int BTN_ROTL  = 3;
  localparam int BTN_ROTR  = 4;
  localparam int BTN_AUX   = 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DELAY     = 2'd1,
    REPEATING = 2'd2
  } repeat_state_t;

  // One spare bit so the terminal count always fits without wrap.
  function automatic int cnt_width(input int max_count);
    return $clog2(max_count) + 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_channel.sv
// btn_channel: one button lane - 2-flop synchroniser, debounce, press pulse and
// optional hold-to-repeat engine.
`default_nettype none

module btn_channel
  import tetris_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 1000000,
  parameter int REPEAT_DELAY_CYCLES = 25000000,
  parameter int REPEAT_RATE_CYCLES  = 8000000,
  parameter bit REPEAT_EN           = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic raw,
  output logic level,
  output logic pulse,
  output logic repeat_active
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int TM_W = cnt_width(max2(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES));
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] DELAY_LAST = TM_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [TM_W-1:0] RATE_LAST  = TM_W'(REPEAT_RATE_CYCLES - 1);

  logic            sync_meta;
  logic            sync;
  logic [DB_W-1:0] db_cnt;
  logic            level_q;
  logic            pulse_q;
  logic            pulse_next;
  repeat_state_t   state;
  repeat_state_t   state_next;
  logic [TM_W-1:0] timer;
  logic [TM_W-1:0] timer_next;

  logic db_diff;
  logic db_done;
  logic level_rise;
  logic level_fall;

  // Rise/fall are decoded before the edge so the pulse and the FSM move in
  // the same cycle that the debounced level changes.
  assign db_diff    = (sync != level_q);
  assign db_done    = db_diff && (db_cnt == DB_LAST);
  assign level_rise = db_done && !level_q;
  assign level_fall = db_done && level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      db_cnt    <= '0;
      level_q   <= 1'b0;
      pulse_q   <= 1'b0;
      state     <= IDLE;
      timer     <= '0;
    end else begin
      sync_meta <= raw;
      sync      <= sync_meta;
      if (!db_diff) begin
        db_cnt <= '0;
      end else if (db_done) begin
        db_cnt  <= '0;
        level_q <= ~level_q;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
      pulse_q <= pulse_next;
      state   <= state_next;
      timer   <= timer_next;
    end
  end

  always_comb begin
    state_next = state;
    timer_next = timer;
    pulse_next = level_rise && enable;
    case (state)
      IDLE: begin
        if (level_rise && enable) begin
          state_next = DELAY;
          timer_next = '0;
        end
      end
      DELAY, REPEATING: begin
        // Release or masking wins over a coincident terminal count.
        if (level_fall || !enable) begin
          state_next = IDLE;
          timer_next = '0;
        end else if (timer == ((state == DELAY) ? DELAY_LAST : RATE_LAST)) begin
          pulse_next = 1'b1;
          state_next = REPEATING;
          timer_next = '0;
        end else begin
          timer_next = timer + TM_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
    if (!REPEAT_EN) begin
      state_next = IDLE;
      timer_next = '0;
    end
  end

  assign level         = level_q;
  assign pulse         = pulse_q && enable;
  assign repeat_active = (state == REPEATING) && enable;

endmodule

`default_nettype wire

// File: rtl/btn_conditioner.sv
// btn_conditioner: N-channel push-button front end producing one-cycle action
// pulses for the tetris game FSM.
`default_nettype none

module btn_conditioner
  import tetris_input_pkg::*;
#(
  parameter int               N_BTN               = 6,
  parameter int               DEBOUNCE_CYCLES     = 1000000,
  parameter int               REPEAT_DELAY_CYCLES = 25000000,
  parameter int               REPEAT_RATE_CYCLES  = 8000000,
  parameter logic [N_BTN-1:0] REPEAT_MASK         = 6'b000111
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_repeat_active
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
      .REPEAT_EN          (REPEAT_MASK[i])
    ) u_channel (
      .clk          (clk_100MHz),
      .rst_n        (reset),
      .enable       (enable),
      .raw          (btn_raw[i]),
      .level        (btn_level[i]),
      .pulse        (btn_pulse[i]),
      .repeat_active(btn_repeat_active[i])
    );
  end

endmodule

`default_nettype wire
